// File: rtl/blink_period_meter_pkg.sv
// Shared definitions for the blink period meter and its companion blinker.
//
// Contents:
//   state_e        measurement FSM state encoding
//   CNT_W_DEF      default cycle-counter / result width
//   BLINK_TOGGLE   half-period of the reference blinker, in CLOCK_50 cycles
//   EXPECTED_DEF   default expected full period (one high plus one low phase)
package blink_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMeasure,
    StStuck
  } state_e;

  localparam int unsigned CNT_W_DEF    = 32;
  // The blinker toggles its LED every BLINK_TOGGLE cycles.
  localparam int unsigned BLINK_TOGGLE = 5001;
  localparam int unsigned EXPECTED_DEF = 2 * BLINK_TOGGLE;

endpackage

// File: rtl/blink_period_meter_if.sv
// Measurement bundle between the meter and whatever consumes its results.
//
// Signals:
//   sig_in        asynchronous square wave fed into the meter
//   period        cycles between the last two accepted rising edges
//   high_time     cycles from the last accepted rising edge to the next falling edge
//   meas_valid    one-cycle pulse when period / period_match update
//   period_match  period is within tolerance of the expected value
//   stuck         no rising edge seen within the timeout
//
// Modports:
//   master  the meter: takes sig_in, drives the results
//   slave   the environment: drives sig_in, observes the results
interface blink_period_meter_if #(
  parameter int unsigned CNT_W = 32
) ();

  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             period_match;
  logic             stuck;

  modport master (
    input  sig_in,
    output period,
    output high_time,
    output meas_valid,
    output period_match,
    output stuck
  );

  modport slave (
    output sig_in,
    input  period,
    input  high_time,
    input  meas_valid,
    input  period_match,
    input  stuck
  );

endinterface

// File: rtl/blink_period_meter_edge_sync.sv
// Multi-flop synchronizer followed by a single-cycle rise/fall detector.
//
// Ports:
//   CLOCK_50  system clock
//   reset     synchronous, active-high; clears all flops to 0
//   sig_in    asynchronous input
//   rise      one-cycle pulse: synchronized input went 0 -> 1
//   fall      one-cycle pulse: synchronized input went 1 -> 0
//
// SYNC_STAGES must be at least 2.
module edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic sig_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sig_s;
  logic                   sig_d_q;

  assign sig_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync_q  <= '0;
      sig_d_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_in};
      sig_d_q <= sig_s;
    end
  end

  assign rise = sig_s & ~sig_d_q;
  assign fall = ~sig_s & sig_d_q;

endmodule

// File: rtl/blink_period_meter.sv
// Measures period and high time of an asynchronous square wave in CLOCK_50
// cycles, flags whether the period is within TOL of EXPECTED, and flags a
// stuck input when no rising edge arrives within TIMEOUT cycles.
//
// Ports:
//   CLOCK_50  system clock (50 MHz)
//   reset     synchronous, active-high
//   bus       blink_period_meter_if.master: sig_in in; period, high_time,
//             meas_valid, period_match, stuck out
//
// The interface instance must be built with the same CNT_W as this module.
// TIMEOUT and SYNC_STAGES must each be at least 2.
module blink_period_meter
  import blink_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned EXPECTED    = EXPECTED_DEF,
  parameter int unsigned TOL         = 2,
  parameter int unsigned TIMEOUT     = 50000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                  CLOCK_50,
  input logic                  reset,
  blink_period_meter_if.master bus
);

  // Interval arithmetic is one bit wider so neither the +1 at saturation nor
  // the |interval - EXPECTED| subtraction can wrap.
  localparam int unsigned CW1 = CNT_W + 1;
  localparam logic [CNT_W:0] EXP_X     = CW1'(EXPECTED);
  localparam logic [CNT_W:0] TOL_X     = CW1'(TOL);
  localparam logic [CNT_W:0] TIMEOUT_X = CW1'(TIMEOUT);

  logic rise;
  logic fall;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .sig_in  (bus.sig_in),
    .rise    (rise),
    .fall    (fall)
  );

  // Cycle counter: interval between two events is cnt + 1.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   interval;
  logic             timeout_hit;

  assign interval    = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign timeout_hit = (interval >= TIMEOUT_X);

  always_comb begin
    cnt_d = cnt_q;
    if (rise) begin
      cnt_d = '0;
    end else if (!(&cnt_q)) begin
      cnt_d = interval[CNT_W-1:0];
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Match comparator on the interval ending at this cycle's rise.
  logic [CNT_W:0] abs_diff;
  logic           match_now;

  always_comb begin
    if (interval >= EXP_X) begin
      abs_diff = interval - EXP_X;
    end else begin
      abs_diff = EXP_X - interval;
    end
    match_now = (abs_diff <= TOL_X);
  end

  // FSM: state register.
  state_e state_q, state_d;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. A rise always beats the timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (rise) begin
          state_d = StMeasure;
        end else if (timeout_hit) begin
          state_d = StStuck;
        end
      end
      StMeasure: begin
        if (!rise && timeout_hit) begin
          state_d = StStuck;
        end
      end
      StStuck: begin
        if (rise) begin
          state_d = StMeasure;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs. Only rises/falls seen in MEASURE produce results; the first
  // rise after IDLE or STUCK just re-arms, so that partial interval is dropped.
  logic load_period;
  logic load_high;
  logic stuck_o;

  always_comb begin
    load_period = 1'b0;
    load_high   = 1'b0;
    stuck_o     = 1'b0;
    unique case (state_q)
      StIdle: ;
      StMeasure: begin
        load_period = rise;
        load_high   = fall;
      end
      StStuck: stuck_o = 1'b1;
      default: ;
    endcase
  end

  // Result registers.
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             match_q, match_d;
  logic             valid_q;

  always_comb begin
    period_d = period_q;
    match_d  = match_q;
    high_d   = high_q;
    if (load_period) begin
      period_d = interval[CNT_W-1:0];
      match_d  = match_now;
    end
    if (load_high) begin
      high_d = interval[CNT_W-1:0];
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      period_q <= '0;
      high_q   <= '0;
      match_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      period_q <= period_d;
      high_q   <= high_d;
      match_q  <= match_d;
      valid_q  <= load_period;
    end
  end

  assign bus.period       = period_q;
  assign bus.high_time    = high_q;
  assign bus.period_match = match_q;
  assign bus.meas_valid   = valid_q;
  assign bus.stuck        = stuck_o;

endmodule

// File: tb/tb_blink_period_meter.sv
// Directed bench for blink_period_meter. dut_a uses the default timeout,
// dut_b a 1000-cycle timeout for the stuck scenarios.
module tb_blink_period_meter;
  import blink_pkg::*;

  localparam int unsigned CW = 32;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;

  always #10 CLOCK_50 = ~CLOCK_50;

  blink_period_meter_if #(.CNT_W(CW)) bus_a ();
  blink_period_meter_if #(.CNT_W(CW)) bus_b ();

  blink_period_meter #(
    .CNT_W(CW), .EXPECTED(EXPECTED_DEF), .TOL(2), .TIMEOUT(50000000), .SYNC_STAGES(2)
  ) dut_a (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .bus     (bus_a)
  );

  blink_period_meter #(
    .CNT_W(CW), .EXPECTED(EXPECTED_DEF), .TOL(2), .TIMEOUT(1000), .SYNC_STAGES(2)
  ) dut_b (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .bus     (bus_b)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Monitor: count meas_valid pulses and snapshot results at each pulse.
  int          mv_cnt_a = 0, mv_cyc_a = 0, mv_prev_a = 0;
  logic [CW-1:0] mv_per_a = '0, mv_high_a = '0;
  logic        mv_match_a = 1'b0;
  int          mv_cnt_b = 0, mv_cyc_b = 0, stuck_cyc_b = 0;
  logic [CW-1:0] mv_per_b = '0, mv_high_b = '0;
  logic        mv_match_b = 1'b0, stuck_prev_b = 1'b0;

  always @(posedge CLOCK_50) cyc++;

  always @(negedge CLOCK_50) begin
    if (bus_a.meas_valid === 1'b1) begin
      mv_cnt_a++;
      mv_prev_a  = mv_cyc_a;
      mv_cyc_a   = cyc;
      mv_per_a   = bus_a.period;
      mv_high_a  = bus_a.high_time;
      mv_match_a = bus_a.period_match;
    end
    if (bus_b.meas_valid === 1'b1) begin
      mv_cnt_b++;
      mv_cyc_b   = cyc;
      mv_per_b   = bus_b.period;
      mv_high_b  = bus_b.high_time;
      mv_match_b = bus_b.period_match;
    end
    if (bus_b.stuck === 1'b1 && stuck_prev_b !== 1'b1) stuck_cyc_b = cyc;
    stuck_prev_b = bus_b.stuck;
  end

  // Hold a level on sig_in for n sampling edges.
  task automatic drive_a(input logic v, input int n);
    bus_a.sig_in = v;
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic drive_b(input logic v, input int n);
    bus_b.sig_in = v;
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    n_cmp++; if (bus_a.period !== '0) begin
      n_fail++; $display("FAIL reset_period: got %0d want 0", bus_a.period); end
    n_cmp++; if (bus_a.high_time !== '0) begin
      n_fail++; $display("FAIL reset_high: got %0d want 0", bus_a.high_time); end
    n_cmp++; if (bus_a.meas_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b want 0", bus_a.meas_valid); end
    n_cmp++; if (bus_a.period_match !== 1'b0) begin
      n_fail++; $display("FAIL reset_match: got %b want 0", bus_a.period_match); end
    n_cmp++; if (bus_a.stuck !== 1'b0) begin
      n_fail++; $display("FAIL reset_stuck: got %b want 0", bus_a.stuck); end
    reset = 1'b0;
  endtask

  task automatic test_blinker();
    int base;
    base = mv_cnt_a;
    drive_a(1'b1, 5001);
    drive_a(1'b0, 5001);
    n_cmp++; if (mv_cnt_a - base !== 0) begin
      n_fail++; $display("FAIL blink_first_rise: got %0d pulses want 0", mv_cnt_a - base); end
    drive_a(1'b1, 5001);
    n_cmp++; if (mv_cnt_a - base !== 1) begin
      n_fail++; $display("FAIL blink_second_rise: got %0d pulses want 1", mv_cnt_a - base); end
    n_cmp++; if (mv_per_a !== 32'd10002) begin
      n_fail++; $display("FAIL blink_period: got %0d want 10002", mv_per_a); end
    n_cmp++; if (mv_high_a !== 32'd5001) begin
      n_fail++; $display("FAIL blink_high: got %0d want 5001", mv_high_a); end
    n_cmp++; if (mv_match_a !== 1'b1) begin
      n_fail++; $display("FAIL blink_match: got %b want 1", mv_match_a); end
    n_cmp++; if (bus_a.stuck !== 1'b0) begin
      n_fail++; $display("FAIL blink_stuck: got %b want 0", bus_a.stuck); end
    drive_a(1'b0, 5001);
    drive_a(1'b1, 5001);
    n_cmp++; if (mv_cnt_a - base !== 2 || mv_per_a !== 32'd10002) begin
      n_fail++; $display("FAIL blink_third_rise: got %0d pulses period %0d want 2 / 10002",
                         mv_cnt_a - base, mv_per_a); end
  endtask

  // Low phase chosen so each period lands on a tolerance boundary.
  task automatic test_tolerance();
    int lows [4] = '{5003, 5004, 4999, 4998};
    int pers [4] = '{10004, 10005, 10000, 9999};
    logic exps [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b0, lows[i]);
      drive_a(1'b1, 5001);
      n_cmp++; if (mv_per_a !== CW'(pers[i]) || mv_match_a !== exps[i]) begin
        n_fail++; $display("FAIL tol_%0d: got period %0d match %b want %0d / %b",
                           i, mv_per_a, mv_match_a, pers[i], exps[i]); end
    end
  endtask

  task automatic test_square();
    int base;
    drive_a(1'b0, 10);
    drive_a(1'b1, 10);
    drive_a(1'b0, 10);
    base = mv_cnt_a;
    repeat (4) begin
      drive_a(1'b1, 10);
      drive_a(1'b0, 10);
    end
    n_cmp++; if (mv_cnt_a - base !== 4) begin
      n_fail++; $display("FAIL sq_pulses: got %0d want 4", mv_cnt_a - base); end
    n_cmp++; if (mv_per_a !== 32'd20) begin
      n_fail++; $display("FAIL sq_period: got %0d want 20", mv_per_a); end
    n_cmp++; if (mv_high_a !== 32'd10) begin
      n_fail++; $display("FAIL sq_high: got %0d want 10", mv_high_a); end
    n_cmp++; if (mv_match_a !== 1'b0) begin
      n_fail++; $display("FAIL sq_match: got %b want 0", mv_match_a); end
    n_cmp++; if (mv_cyc_a - mv_prev_a !== 20) begin
      n_fail++; $display("FAIL sq_spacing: got %0d want 20", mv_cyc_a - mv_prev_a); end
  endtask

  task automatic test_stuck();
    int base;
    int waited;
    n_cmp++; if (bus_b.stuck !== 1'b1) begin
      n_fail++; $display("FAIL stuck_from_idle: got %b want 1", bus_b.stuck); end
    base = mv_cnt_b;
    drive_b(1'b1, 50);
    n_cmp++; if (bus_b.stuck !== 1'b0 || mv_cnt_b - base !== 0) begin
      n_fail++; $display("FAIL stuck_exit: got stuck %b pulses %0d want 0 / 0",
                         bus_b.stuck, mv_cnt_b - base); end
    drive_b(1'b0, 50);
    drive_b(1'b1, 50);
    n_cmp++; if (mv_cnt_b - base !== 1 || mv_per_b !== 32'd100 || mv_high_b !== 32'd50) begin
      n_fail++; $display("FAIL stuck_meas: got pulses %0d period %0d high %0d want 1 / 100 / 50",
                         mv_cnt_b - base, mv_per_b, mv_high_b); end
    bus_b.sig_in = 1'b0;
    waited = 0;
    while (bus_b.stuck !== 1'b1 && waited < 1200) begin
      @(posedge CLOCK_50);
      waited++;
    end
    @(negedge CLOCK_50);
    #1;
    n_cmp++; if (bus_b.stuck !== 1'b1) begin
      n_fail++; $display("FAIL stuck_timeout: got %b want 1 after %0d cycles", bus_b.stuck,
                         waited); end
    n_cmp++; if (stuck_cyc_b - mv_cyc_b !== 1000) begin
      n_fail++; $display("FAIL stuck_delay: got %0d want 1000", stuck_cyc_b - mv_cyc_b); end
    n_cmp++; if (bus_b.period !== 32'd100 || bus_b.high_time !== 32'd50) begin
      n_fail++; $display("FAIL stuck_hold: got period %0d high %0d want 100 / 50",
                         bus_b.period, bus_b.high_time); end
    drive_b(1'b1, 30);
    n_cmp++; if (bus_b.stuck !== 1'b0 || mv_cnt_b - base !== 1) begin
      n_fail++; $display("FAIL stuck_recover: got stuck %b pulses %0d want 0 / 1",
                         bus_b.stuck, mv_cnt_b - base); end
    drive_b(1'b0, 30);
    drive_b(1'b1, 30);
    n_cmp++; if (mv_cnt_b - base !== 2 || mv_per_b !== 32'd60 || mv_high_b !== 32'd30) begin
      n_fail++; $display("FAIL stuck_remeas: got pulses %0d period %0d high %0d want 2 / 60 / 30",
                         mv_cnt_b - base, mv_per_b, mv_high_b); end
    drive_b(1'b0, 5);
  endtask

  task automatic test_reset_mid();
    int base;
    drive_a(1'b1, 10);
    drive_a(1'b0, 5);
    reset = 1'b1;
    @(posedge CLOCK_50);
    #1;
    reset = 1'b0;
    @(negedge CLOCK_50);
    n_cmp++; if (bus_a.period !== '0 || bus_a.high_time !== '0) begin
      n_fail++; $display("FAIL mid_reset_regs: got period %0d high %0d want 0 / 0",
                         bus_a.period, bus_a.high_time); end
    n_cmp++; if ({bus_a.meas_valid, bus_a.period_match, bus_a.stuck} !== 3'b000) begin
      n_fail++; $display("FAIL mid_reset_flags: got %b%b%b want 000", bus_a.meas_valid,
                         bus_a.period_match, bus_a.stuck); end
    base = mv_cnt_a;
    drive_a(1'b0, 5);
    drive_a(1'b1, 20);
    n_cmp++; if (mv_cnt_a - base !== 0) begin
      n_fail++; $display("FAIL mid_first_rise: got %0d pulses want 0", mv_cnt_a - base); end
    drive_a(1'b0, 20);
    drive_a(1'b1, 20);
    n_cmp++; if (mv_cnt_a - base !== 1 || mv_per_a !== 32'd40 || mv_high_a !== 32'd20) begin
      n_fail++; $display("FAIL mid_second_rise: got pulses %0d period %0d high %0d want 1/40/20",
                         mv_cnt_a - base, mv_per_a, mv_high_a); end
    drive_a(1'b0, 5);
  endtask

  task automatic test_high_at_reset();
    int base;
    bus_a.sig_in = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    #1;
    reset = 1'b0;
    base = mv_cnt_a;
    drive_a(1'b1, 10);
    n_cmp++; if (mv_cnt_a - base !== 0) begin
      n_fail++; $display("FAIL hr_spurious: got %0d pulses want 0", mv_cnt_a - base); end
    drive_a(1'b0, 10);
    drive_a(1'b1, 10);
    n_cmp++; if (mv_cnt_a - base !== 1 || mv_per_a !== 32'd20) begin
      n_fail++; $display("FAIL hr_first_meas: got pulses %0d period %0d want 1 / 20",
                         mv_cnt_a - base, mv_per_a); end
    drive_a(1'b0, 10);
    drive_a(1'b1, 10);
    n_cmp++; if (mv_cnt_a - base !== 2 || mv_per_a !== 32'd20 || mv_high_a !== 32'd10) begin
      n_fail++; $display("FAIL hr_second_meas: got pulses %0d period %0d high %0d want 2/20/10",
                         mv_cnt_a - base, mv_per_a, mv_high_a); end
  endtask

  initial begin
    bus_a.sig_in = 1'b0;
    bus_b.sig_in = 1'b0;
    test_reset();
    test_blinker();
    test_tolerance();
    test_square();
    test_stuck();
    test_reset_mid();
    test_high_at_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
